// File: rtl/conv_maxpool2x2.sv
// 2x2 / stride-2 signed max-pool over the convolver result stream, using a half-row line buffer.
// Optional fused ReLU on the input samples when POOL_RELU_EN is defined.
module conv_maxpool2x2 #(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_SIZE  = 28,
  parameter int KERNEL_SIZE = 5
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  output logic [4:0]                   out_row,
  output logic [4:0]                   out_col,
  output logic                         frame_done
);

  localparam int CONV_DIM = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int HALF     = CONV_DIM / 2;
  localparam int CW       = $clog2(CONV_DIM);
  localparam logic [CW-1:0] LAST = CW'(CONV_DIM - 1);

  if ((CONV_DIM % 2) != 0) begin : g_bad_dim
    $error("conv_maxpool2x2: CONV_DIM must be even");
  end

  typedef enum logic {EVEN_ROW, ODD_ROW} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]                col, row;
  logic [CW-2:0]                lb_idx;
  logic signed [DATA_WIDTH-1:0] din, pair_q, m, lb_rd, pool;
  logic signed [DATA_WIDTH-1:0] linebuf [HALF];
  logic                         accept, col_odd, col_last, row_last;
  logic                         lb_we, emit;

  always_comb begin
`ifdef POOL_RELU_EN
    din = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
    din = in_data;
`endif
  end

  assign accept   = in_valid & ~clear;
  assign col_odd  = col[0];
  assign col_last = (col == LAST);
  assign row_last = (row == LAST);
  assign lb_idx   = col[CW-1:1];

  assign m     = (pair_q > din) ? pair_q : din;
  assign lb_rd = linebuf[lb_idx];
  assign pool  = (lb_rd > m) ? lb_rd : m;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= EVEN_ROW;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    lb_we   = 1'b0;
    emit    = 1'b0;
    if (clear) begin
      state_d = EVEN_ROW;
    end else if (accept) begin
      case (state_q)
        EVEN_ROW: begin
          lb_we = col_odd;
          if (col_last) state_d = ODD_ROW;
        end
        ODD_ROW: begin
          emit = col_odd;
          if (col_last) state_d = EVEN_ROW;
        end
        default: state_d = EVEN_ROW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col    <= '0;
      row    <= '0;
      pair_q <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (!col_odd) pair_q <= din;
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffer holds the even-row pair maxima; it is fully rewritten before each odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[lb_idx] <= m;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit & row_last & col_last;
      if (emit) begin
        out_data <= pool;
        out_row  <= 5'(row >> 1);
        out_col  <= 5'(col >> 1);
      end
    end
  end

endmodule

// File: tb/tb_conv_maxpool2x2.sv
// Scoreboard bench for conv_maxpool2x2: a frame-array reference model predicts each pooled output.
module tb_conv_maxpool2x2;

  localparam int DW   = 16;
  localparam int IMG  = 28;
  localparam int K    = 5;
  localparam int DIM  = IMG - K + 1;
  localparam int FULL = DIM * DIM;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 clear;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic [4:0]           out_row;
  logic [4:0]           out_col;
  logic                 frame_done;

  conv_maxpool2x2 #(.DATA_WIDTH(DW), .IMAGE_SIZE(IMG), .KERNEL_SIZE(K)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int row;
    int col;
    int fd;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   fm [DIM][DIM];
  int   mr = 0, mc = 0;
  int   cyc = 0;
  int   errors = 0, checks = 0;
  int   n_out = 0, n_fd = 0, first00 = -1;
  int   last_data = 0, last_row = 0, last_col = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int relu(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One clock of stimulus; the model records the sample and predicts the pooled output it completes.
  task automatic step(input bit v, input int d, input bit clr);
    exp_t e;
    in_valid = v;
    in_data  = DW'(d);
    clear    = clr;
    if (clr) begin
      mr = 0;
      mc = 0;
    end else if (v) begin
      fm[mr][mc] = relu(d);
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
        e.data = max2(max2(fm[mr-1][mc-1], fm[mr-1][mc]), max2(fm[mr][mc-1], fm[mr][mc]));
        e.row  = mr / 2;
        e.col  = mc / 2;
        e.fd   = (mr == DIM-1 && mc == DIM-1) ? 1 : 0;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
      mc++;
      if (mc == DIM) begin
        mc = 0;
        mr = (mr + 1) % DIM;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  // mode 0: ramp, 1: negative frame, 2: random data; gaps 1: control-path bubbles, 2: random bubbles
  task automatic send_frame(input int mode, input int gaps, input int stop_at);
    logic signed [DW-1:0] r16;
    int d;
    if (gaps == 1) idle(K*K);
    for (int idx = 0; idx < stop_at; idx++) begin
      case (mode)
        0: d = idx;
        1: d = (idx == DIM) ? -2 : -5;
        default: begin
          r16 = DW'($urandom);
          d   = int'(r16);
        end
      endcase
      step(1'b1, d, 1'b0);
      if (gaps == 1 && (idx % DIM) == DIM-1) idle(K-1);
      if (gaps == 2) idle($urandom_range(0, 2));
    end
  endtask

  task automatic start_test();
    n_out   = 0;
    n_fd    = 0;
    first00 = -1;
  endtask

  task automatic end_test(input string name, input int outs, input int fds);
    idle(3);
    chk({name, " pending"}, exp_q.size(), 0);
    chk({name, " outputs"}, n_out, outs);
    chk({name, " frame_done"}, n_fd, fds);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, " out_data"}, int'(out_data), 0);
    chk({name, " out_valid"}, int'(out_valid), 0);
    chk({name, " out_row"}, int'(out_row), 0);
    chk({name, " out_col"}, int'(out_col), 0);
    chk({name, " frame_done"}, int'(frame_done), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", cyc, e.cyc);
          chk("out_data", int'(out_data), e.data);
          chk("out_row", int'(out_row), e.row);
          chk("out_col", int'(out_col), e.col);
          chk("frame_done", int'(frame_done), e.fd);
          last_data = e.data;
          last_row  = e.row;
          last_col  = e.col;
          n_out++;
          if (frame_done) n_fd++;
          if (first00 < 0 && out_row == 0 && out_col == 0) first00 = int'(out_data);
        end
      end else begin
        chk("frame_done idle", int'(frame_done), 0);
        chk("hold out_data", int'(out_data), last_data);
        chk("hold out_row", int'(out_row), last_row);
        chk("hold out_col", int'(out_col), last_col);
      end
    end
  end

  initial begin
    rstn     = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    check_zero_outputs("reset");
    #8 rstn = 1'b1;
    @(posedge clk);
    #1;

    start_test();
    send_frame(0, 0, FULL);
    end_test("ramp", FULL/4, 1);

    start_test();
    send_frame(1, 0, FULL);
    end_test("negative", FULL/4, 1);
`ifdef POOL_RELU_EN
    chk("negative first", first00, 0);
`else
    chk("negative first", first00, -2);
`endif

    start_test();
    send_frame(0, 1, FULL);
    end_test("gapped", FULL/4, 1);

    send_frame(0, 0, 100);
    step(1'b1, 12345, 1'b1);
    start_test();
    send_frame(0, 0, FULL);
    end_test("clear", FULL/4, 1);
    chk("clear first", first00, 25);

    start_test();
    send_frame(0, 0, FULL);
    send_frame(0, 0, FULL);
    end_test("b2b", FULL/2, 2);

    send_frame(0, 0, 300);
    in_valid = 1'b1;
    in_data  = DW'(300);
    #2 rstn = 1'b0;
    #1;
    check_zero_outputs("async reset");
    in_valid = 1'b0;
    exp_q.delete();
    mr = 0;
    mc = 0;
    last_data = 0;
    last_row  = 0;
    last_col  = 0;
    @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    start_test();
    send_frame(0, 0, FULL);
    end_test("after reset", FULL/4, 1);

    start_test();
    send_frame(2, 2, FULL);
    end_test("random", FULL/4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
